block_word_serializer: RTL and testbench

Splits one 128-bit block (AES state/ciphertext) into four 32-bit words and emits them one per accepted handshake. It is the transmit side of the word-assembly path: a downstream word-indexed collector rebuilds the block from these words. It sits between the AES core output register and the 32-bit bus/export interface. A valid/ready handshake is used on both sides, and back-to-back blocks run at full throughput.

---
 rtl/block_word_serializer.sv | 101 ++++++++++
 tb/tb_block_word_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_word_serializer.sv
// block_word_serializer: splits one WORD_W*NUM_WORDS-bit block into NUM_WORDS
// words and emits one word per accepted out_valid/out_ready handshake.
// Back-to-back blocks are accepted on the last word's handshake, so there is
// no bubble between blocks.
// Build option: define REVERSE_ORDER_EN to emit the least-significant word
// first. The default build emits the most-significant word first.
module block_word_serializer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WORD_W*NUM_WORDS-1:0] in_block,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WORD_W-1:0]           out_word,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                        state;
    logic [IDX_W-1:0]              cnt;
    logic [WORD_W*NUM_WORDS-1:0]   hold;

    // Block capture, word counting and the IDLE/SEND state machine.
    // NOTE: hold is reset as well (not just the control state) because out_word
    // is a direct combinational view of it and must read zero after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the values from before the clock edge.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold  <= in_block;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (cnt == LAST_IDX) begin
                            cnt <= '0;
                            if (in_valid) begin
                                // Next block loaded on the last word: no bubble.
                                hold <= in_block;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the word of hold addressed by cnt in emission order.
    always_comb begin
        // NOTE: the default assignment first guarantees out_word is written on
        // every path, so no latch is inferred for unmatched cnt values.
        out_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt == IDX_W'(k)) begin
`ifdef REVERSE_ORDER_EN
                out_word = hold[k*WORD_W +: WORD_W];
`else
                out_word = hold[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
`endif
            end
        end
    end

    // Output flags decoded from the state register and the word counter.
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_idx   = cnt;
    assign out_last  = (state == SEND) && (cnt == LAST_IDX);
    // Ready opens early on the last word's handshake so a waiting block is
    // taken in the same cycle the final word leaves.
    assign in_ready  = (state == IDLE) ||
                       ((state == SEND) && (cnt == LAST_IDX) && out_ready);

endmodule

// File: tb/tb_block_word_serializer.sv
// Self-checking bench for block_word_serializer. A queue-based reference model
// expands each accepted block into its expected (word, idx) sequence and is
// compared against the DUT every cycle. Define REVERSE_ORDER_EN for both the
// bench and the RTL to check the reversed build.
module tb_block_word_serializer;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int IDX_W     = 2;
    localparam int BLK_W     = WORD_W * NUM_WORDS;
    localparam int BUDGET    = 4000;

    logic               CLK;
    logic               RESET;
    logic [BLK_W-1:0]   in_block;
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  out_word;
    logic [IDX_W-1:0]   out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [BLK_W-1:0] src_q[$];
    int max_run;

    block_word_serializer #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .IDX_W    (IDX_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_block (in_block),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_word (out_word),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word k in emission order, computed by shifting the block.
    function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] blk, input int k);
        logic [BLK_W-1:0] sh;
`ifdef REVERSE_ORDER_EN
        sh = blk >> (WORD_W * k);
`else
        sh = blk >> (WORD_W * (NUM_WORDS - 1 - k));
`endif
        return sh[WORD_W-1:0];
    endfunction

    function automatic logic [BLK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Drives blocks from src_q and checks every cycle against the model.
    task automatic run_stream(input int ready_pct, input int gap_pct);
        logic [WORD_W-1:0] wq[$];
        int                iq[$];
        int                cycles = 0;
        int                run    = 0;
        bit                offering = 0;
        bit                exp_rdy;
        max_run = 0;
        while ((src_q.size() > 0 || wq.size() > 0) && cycles < BUDGET) begin
            if (!offering && src_q.size() > 0 && int'($urandom_range(99)) >= gap_pct)
                offering = 1;
            in_valid  = offering;
            in_block  = offering ? src_q[0] : rand_block();
            out_ready = (int'($urandom_range(99)) < ready_pct);
            @(negedge CLK);
            exp_rdy = (wq.size() == 0) || (wq.size() == 1 && out_ready);
            chk_bit("out_valid", out_valid, wq.size() > 0);
            chk_bit("busy", busy, wq.size() > 0);
            chk_bit("in_ready", in_ready, exp_rdy);
            if (wq.size() > 0) begin
                chk_word("out_word", out_word, wq[0]);
                chk_int("out_idx", int'(out_idx), iq[0]);
                chk_bit("out_last", out_last, iq[0] == NUM_WORDS - 1);
                run++;
                if (run > max_run) max_run = run;
                if (out_ready) begin
                    void'(wq.pop_front());
                    void'(iq.pop_front());
                end
            end else begin
                chk_bit("out_last_idle", out_last, 1'b0);
                run = 0;
            end
            if (in_valid && exp_rdy) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    wq.push_back(word_of(src_q[0], k));
                    iq.push_back(k);
                end
                void'(src_q.pop_front());
                offering = 0;
            end
            next_cycle();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cycles >= BUDGET) begin
            errors++;
            $display("FAIL stream_timeout cycles=%0d limit=%0d", cycles, BUDGET);
        end
        @(negedge CLK);
        chk_bit("idle_after_stream", out_valid, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_block = '0;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_word("rst_out_word", out_word, '0);
        chk_int("rst_out_idx", int'(out_idx), 0);
        chk_bit("rst_out_last", out_last, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        RESET = 1'b0;
        next_cycle();
        @(negedge CLK);
        chk_bit("post_rst_in_ready", in_ready, 1'b1);
        next_cycle();
    endtask

    task automatic test_single();
        logic [BLK_W-1:0] blk;
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`ifdef REVERSE_ORDER_EN
        chk_word("ref_first_word", word_of(blk, 0), 32'hCCDDEEFF);
`else
        chk_word("ref_first_word", word_of(blk, 0), 32'h00112233);
`endif
        src_q.push_back(blk);
        run_stream(100, 0);
    endtask

    task automatic test_backpressure();
        logic [BLK_W-1:0] blk;
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        in_block  = blk;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        chk_bit("bp_accept", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        in_block = rand_block();
        @(negedge CLK);
        chk_word("bp_w0", out_word, word_of(blk, 0));
        next_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_word("bp_stall_word", out_word, word_of(blk, 1));
            chk_int("bp_stall_idx", int'(out_idx), 1);
            chk_bit("bp_stall_valid", out_valid, 1'b1);
            chk_bit("bp_stall_in_ready", in_ready, 1'b0);
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 1; k < NUM_WORDS; k++) begin
            @(negedge CLK);
            chk_word("bp_resume_word", out_word, word_of(blk, k));
            chk_int("bp_resume_idx", int'(out_idx), k);
            chk_bit("bp_resume_last", out_last, k == NUM_WORDS - 1);
            next_cycle();
        end
        @(negedge CLK);
        chk_bit("bp_idle", out_valid, 1'b0);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        src_q.push_back(rand_block());
        src_q.push_back(rand_block());
        run_stream(100, 0);
        chk_int("b2b_consecutive_valid", max_run, 2 * NUM_WORDS);
    endtask

    // Block C offered while A is still being sent must wait for A's last word.
    task automatic test_hold_off();
        logic [BLK_W-1:0] a;
        logic [BLK_W-1:0] c;
        a = rand_block();
        c = rand_block();
        in_block = a;
        in_valid = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        in_block = c;
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            @(negedge CLK);
            chk_bit("ho_in_ready_low", in_ready, 1'b0);
            chk_word("ho_a_word", out_word, word_of(a, k));
            next_cycle();
        end
        @(negedge CLK);
        chk_bit("ho_in_ready_last", in_ready, 1'b1);
        chk_word("ho_a_last", out_word, word_of(a, NUM_WORDS - 1));
        next_cycle();
        in_valid = 1'b0;
        in_block = rand_block();
        for (int k = 0; k < NUM_WORDS; k++) begin
            @(negedge CLK);
            chk_word("ho_c_word", out_word, word_of(c, k));
            chk_int("ho_c_idx", int'(out_idx), k);
            next_cycle();
        end
        @(negedge CLK);
        chk_bit("ho_idle", out_valid, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [BLK_W-1:0] a;
        a = rand_block();
        in_block = a;
        in_valid = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        // idx 0 and idx 1 have been consumed; idx 2 is now presented.
        @(negedge CLK);
        chk_int("rm_idx_before", int'(out_idx), 2);
        RESET = 1'b1;
        out_ready = 1'b0;
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        chk_bit("rm_out_valid", out_valid, 1'b0);
        chk_bit("rm_busy", busy, 1'b0);
        chk_word("rm_out_word", out_word, '0);
        chk_bit("rm_in_ready", in_ready, 1'b1);
        next_cycle();
        src_q.push_back(rand_block());
        run_stream(100, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) src_q.push_back(rand_block());
        run_stream(60, 40);
    endtask

    initial begin
        RESET = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_hold_off();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
